// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with scrub-on-reset FSM and per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int REG_COUNT = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              ready,
  input  logic [RD_PORTS-1:0]               rd_en,
  input  logic [RD_PORTS-1:0][AW-1:0]       rd_addr,
  output logic [RD_PORTS-1:0][XLEN-1:0]     rd_data,
  output logic [RD_PORTS-1:0]               rd_busy,
  input  logic [WR_PORTS-1:0]               wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]       wr_addr,
  input  logic [WR_PORTS-1:0][XLEN-1:0]     wr_data,
  input  logic                              busy_set_en,
  input  logic [AW-1:0]                     busy_set_addr
);
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy, busy_nxt;
  logic [WR_PORTS-1:0] wr_ok;
  logic set_ok;
  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) wr_ok[w] = ready && wr_en[w] && wr_addr[w] != '0;
  end
  assign set_ok = ready && busy_set_en && busy_set_addr != '0;
  // set is applied after the clears so it wins on a collision
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < WR_PORTS; w++) if (wr_ok[w]) busy_nxt[wr_addr[w]] = 1'b0;
    if (set_ok) busy_nxt[busy_set_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= AW'(1);
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      busy <= busy_nxt;
      if (state == INIT) begin
        cnt <= cnt + AW'(1);
        if (cnt == AW'(REG_COUNT - 1)) begin
          state <= READY;
          ready <= 1'b1;
        end
      end
    end
  end
  // storage has no reset; the scrub defines it, later ports overwrite earlier ones
  always_ff @(posedge clk) begin
    if (!ready) regs[cnt] <= '0;
    else for (int w = 0; w < WR_PORTS; w++) if (wr_ok[w]) regs[wr_addr[w]] <= wr_data[w];
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (ready && rd_en[p] && rd_addr[p] != '0) begin
        rd_data[p] = regs[rd_addr[p]];
        rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < WR_PORTS; w++) begin
          if (wr_ok[w] && wr_addr[w] == rd_addr[p]) begin
            rd_data[p] = wr_data[w];
            rd_busy[p] = set_ok && busy_set_addr == rd_addr[p];
          end
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of scrub, writes, busy scoreboard, reset and optional forwarding.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             a_ready;
  logic [1:0]       a_rd_en;
  logic [1:0][4:0]  a_rd_addr;
  logic [1:0][31:0] a_rd_data;
  logic [1:0]       a_rd_busy;
  logic [1:0]       a_wr_en;
  logic [1:0][4:0]  a_wr_addr;
  logic [1:0][31:0] a_wr_data;
  logic             a_set_en;
  logic [4:0]       a_set_addr;

  logic             b_ready;
  logic [2:0]       b_rd_en;
  logic [2:0][3:0]  b_rd_addr;
  logic [2:0][63:0] b_rd_data;
  logic [2:0]       b_rd_busy;
  logic [1:0]       b_wr_en;
  logic [1:0][3:0]  b_wr_addr;
  logic [1:0][63:0] b_wr_data;
  logic             b_set_en;
  logic [3:0]       b_set_addr;

  int errors = 0;
  int checks = 0;
  int na, nb;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .ready(a_ready),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy_set_en(a_set_en), .busy_set_addr(a_set_addr)
  );

  regfile_mp #(.XLEN(64), .REG_COUNT(16), .RD_PORTS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(b_ready),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy_set_en(b_set_en), .busy_set_addr(b_set_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scrub_wait(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_ready && ca == 0) ca = i;
      if (b_ready && cb == 0) cb = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_rd_en = '0; a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_set_en = 1'b0; a_set_addr = '0;
    b_rd_en = '0; b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_set_en = 1'b0; b_set_addr = '0;
    repeat (2) tick();
    a_rd_en = 2'b11; a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd7;
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_rd_data", a_rd_data[0], 0);
    chk("rst_rd_busy", a_rd_busy, 0);

    rst_n = 1'b1;
    scrub_wait(na, nb);
    chk("scrub_cycles_a", na, 31);
    chk("scrub_cycles_b", nb, 15);
    chk("x5_after_scrub", a_rd_data[0], 0);

    // two ports write x5 together, port 1 must win
    a_wr_en = 2'b11;
    a_wr_addr[0] = 5'd5; a_wr_data[0] = 32'hDEADBEEF;
    a_wr_addr[1] = 5'd5; a_wr_data[1] = 32'h12345678;
    a_rd_addr[0] = 5'd5;
    #1;
    chk("x5_same_cycle", a_rd_data[0], BYP ? 64'h12345678 : 64'h0);
    tick();
    a_wr_en = '0;
    #1;
    chk("x5_port_priority", a_rd_data[0], 64'h12345678);

    a_wr_en = 2'b11;
    a_wr_addr[0] = 5'd0;  a_wr_data[0] = 32'hFFFFFFFF;
    a_wr_addr[1] = 5'd31; a_wr_data[1] = 32'hFFFF0000;
    tick();
    a_wr_en = '0;
    a_rd_addr[0] = 5'd0; a_rd_addr[1] = 5'd31;
    #1;
    chk("x0_reads_zero", a_rd_data[0], 0);
    chk("x31_write", a_rd_data[1], 64'hFFFF0000);
    a_rd_en = 2'b01;
    #1;
    chk("rd_en_off_data", a_rd_data[1], 0);
    a_rd_en = 2'b11;

    a_wr_en = 2'b11;
    a_wr_addr[0] = 5'd1; a_wr_data[0] = 32'h11111111;
    a_wr_addr[1] = 5'd2; a_wr_data[1] = 32'h22222222;
    tick();
    a_wr_en = '0;
    a_rd_addr[0] = 5'd1; a_rd_addr[1] = 5'd2;
    #1;
    chk("x1_write", a_rd_data[0], 64'h11111111);
    chk("x2_write", a_rd_data[1], 64'h22222222);

    // busy scoreboard on x7
    a_set_en = 1'b1; a_set_addr = 5'd7; a_rd_addr[0] = 5'd7; a_rd_addr[1] = 5'd0;
    #1;
    chk("busy_before_set_edge", a_rd_busy[0], 0);
    tick();
    a_set_en = 1'b0;
    #1;
    chk("busy_after_set", a_rd_busy[0], 1);
    chk("busy_x0", a_rd_busy[1], 0);
    tick();
    chk("busy_holds", a_rd_busy[0], 1);
    a_rd_en = 2'b10;
    #1;
    chk("busy_rd_en_off", a_rd_busy[0], 0);
    a_rd_en = 2'b11;
    a_wr_en = 2'b01; a_wr_addr[0] = 5'd7; a_wr_data[0] = 32'hA5A5A5A5;
    #1;
    chk("busy_during_write", a_rd_busy[0], BYP ? 64'h0 : 64'h1);
    chk("x7_during_write", a_rd_data[0], BYP ? 64'hA5A5A5A5 : 64'h0);
    tick();
    a_wr_en = '0;
    #1;
    chk("busy_cleared", a_rd_busy[0], 0);
    chk("x7_write", a_rd_data[0], 64'hA5A5A5A5);
    a_set_en = 1'b1; a_set_addr = 5'd7;
    a_wr_en = 2'b01; a_wr_data[0] = 32'h5A5A5A5A;
    #1;
    chk("busy_set_and_write_pre", a_rd_busy[0], BYP ? 64'h1 : 64'h0);
    tick();
    a_set_en = 1'b0; a_wr_en = '0;
    #1;
    chk("busy_set_wins", a_rd_busy[0], 1);
    chk("x7_rewrite", a_rd_data[0], 64'h5A5A5A5A);

    a_wr_en = 2'b01; a_wr_addr[0] = 5'd3; a_wr_data[0] = 32'h0000CAFE; a_rd_addr[1] = 5'd3;
    #1;
    chk("x3_same_cycle", a_rd_data[1], BYP ? 64'h0000CAFE : 64'h0);
    tick();
    a_wr_en = '0;
    #1;
    chk("x3_after_edge", a_rd_data[1], 64'h0000CAFE);

    b_wr_en = 2'b10; b_wr_addr[1] = 4'd9; b_wr_data[1] = 64'h0123456789ABCDEF;
    b_rd_en = 3'b111; b_rd_addr[0] = 4'd9; b_rd_addr[1] = 4'd9; b_rd_addr[2] = 4'd9;
    tick();
    b_wr_en = '0;
    #1;
    chk("b_port0", b_rd_data[0], 64'h0123456789ABCDEF);
    chk("b_port1", b_rd_data[1], 64'h0123456789ABCDEF);
    chk("b_port2", b_rd_data[2], 64'h0123456789ABCDEF);

    // x7 is still busy here; reset must clear it and the scrub must wipe data
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", a_ready, 0);
    chk("rst_async_busy", a_rd_busy, 0);
    chk("rst_async_data", a_rd_data[0], 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_scrub_ready", a_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_scrub_rst_ready", a_ready, 0);
    tick();
    rst_n = 1'b1;
    scrub_wait(na, nb);
    chk("rescrub_cycles", na, 31);
    a_rd_addr[0] = 5'd7;
    #1;
    chk("busy_after_reset", a_rd_busy[0], 0);
    for (int r = 0; r < 32; r++) begin
      a_rd_addr[0] = 5'(r);
      #1;
      chk($sformatf("scrub_x%0d", r), a_rd_data[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, giving the number of architectural registers (x0..x(REG_COUNT-1)); AW = clog2(REG_COUNT).
REQ-003 The block SHALL have parameter RD_PORTS, default 2, giving the number of read ports.
REQ-004 The block SHALL have parameter WR_PORTS, default 2, giving the number of write ports.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have these ports:
- ready  out  1  scrub complete, register file usable.
- rd_en  in  RD_PORTS  per-port read enable.
- rd_addr  in  RD_PORTS x AW  per-port read address.
- rd_data  out  RD_PORTS x XLEN  per-port read data.
- rd_busy  out  RD_PORTS  per-port scoreboard busy flag of the addressed register.
- wr_en  in  WR_PORTS  per-port write enable.
- wr_addr  in  WR_PORTS x AW  per-port write address.
- wr_data  in  WR_PORTS x XLEN  per-port write data.
- busy_set_en  in  1  mark a destination register pending.
- busy_set_addr  in  AW  register to mark pending.

Function
REQ-007 Reads SHALL be combinational; rd_data[p] SHALL be 0 when rd_en[p]=0, rd_addr[p]=0, or ready=0, else the stored value.
REQ-008 Writes SHALL take effect on the rising clk edge; writes to x0 and all writes while ready=0 SHALL be ignored.
REQ-009 When several write ports target the same nonzero address in one cycle, the highest-indexed port SHALL win.
REQ-010 The scrub FSM SHALL have exactly two states, INIT and READY; in INIT a counter starting at 1 SHALL write 0 to register[counter] each cycle and increment.
REQ-011 The FSM SHALL move INIT->READY on the edge that writes register REG_COUNT-1, so ready rises REG_COUNT-1 cycles after rst_n deasserts; READY SHALL be held until reset.
REQ-012 Each register 1..REG_COUNT-1 SHALL have a busy bit; busy_set_en with a nonzero busy_set_addr SHALL set it on the next edge, and any accepted write to that register SHALL clear it.
REQ-013 When busy set and write clear target the same register in one cycle, set SHALL win; busy_set_en SHALL be ignored while ready=0.
REQ-014 rd_busy[p] SHALL be 0 for x0, for rd_en[p]=0, and while ready=0; otherwise it SHALL be the registered busy bit.

Reset
REQ-015 Asserting rst_n low at any time, including mid-scrub or mid-write, SHALL immediately force FSM=INIT, counter=1, ready=0, and all busy bits=0.
REQ-016 While rst_n is low, rd_data and rd_busy SHALL read 0; register contents SHALL be defined only after the scrub completes.

Configuration
REQ-017 With macro REGFILE_BYPASS_EN defined, a read whose address matches an accepted write in the same cycle SHALL return that write's data (highest matching port), and rd_busy SHALL return 0 for that register unless a busy set targets it in the same cycle.
REQ-018 Without REGFILE_BYPASS_EN, reads SHALL return only the pre-edge stored value and the registered busy bit, with no forwarding logic.

Verification
REQ-019 Release reset, default params -> ready=0 for 31 cycles, rises on cycle 31; all registers then read 0.
REQ-020 After ready: wr0 x5=0xDEADBEEF and wr1 x5=0x12345678 in the same cycle -> next cycle rd x5 = 0x12345678; write x0=0xFFFFFFFF -> rd x0 = 0.
REQ-021 busy_set x7, then write x7=0xA5A5A5A5 -> rd_busy=1 until the write edge, then 0; busy_set x7 and write x7 in the same cycle -> busy stays 1.
REQ-022 rst_n pulsed low during scrub (counter=10) -> ready=0, busy clear; the full 31-cycle scrub restarts.
REQ-023 With REGFILE_BYPASS_EN: write x3=0x0000CAFE while reading x3 in the same cycle -> rd_data=0x0000CAFE in that cycle; without the macro -> the old value is read.
REQ-024 XLEN=64, REG_COUNT=16, RD_PORTS=3 -> scrub takes 15 cycles; a 64-bit write appears on all three read ports.
